mem_arbiter: RTL and testbench

Two-client arbiter between the instruction cache, the data cache and the single shared main-memory port. Each client drives the same request/data/response handshake that a cache presents on its memory side. The arbiter grants one transaction at a time, round-robin, and holds the grant until the transaction finishes: one address beat plus one data beat for a write, one address beat plus BEATS response beats for a read. It forwards the owner's signals to memory and routes memory responses back to the owner only.

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the icache (c0) and dcache (c1).
// Holds the grant for one full transaction: address + write beat, or address + BEATS read beats.
module mem_arbiter #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int BEATS     = 4
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   c0_req_valid,
  output logic                   c0_req_ready,
  input  logic [ADDR_BITS-1:0]   c0_req_addr,
  input  logic                   c0_req_rw,
  input  logic                   c0_req_data_valid,
  output logic                   c0_req_data_ready,
  input  logic [DATA_BITS-1:0]   c0_req_data_bits,
  input  logic [DATA_BITS/8-1:0] c0_req_data_mask,
  output logic                   c0_resp_valid,
  output logic [DATA_BITS-1:0]   c0_resp_data,

  input  logic                   c1_req_valid,
  output logic                   c1_req_ready,
  input  logic [ADDR_BITS-1:0]   c1_req_addr,
  input  logic                   c1_req_rw,
  input  logic                   c1_req_data_valid,
  output logic                   c1_req_data_ready,
  input  logic [DATA_BITS-1:0]   c1_req_data_bits,
  input  logic [DATA_BITS/8-1:0] c1_req_data_mask,
  output logic                   c1_resp_valid,
  output logic [DATA_BITS-1:0]   c1_resp_data,

  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int MASK_BITS = DATA_BITS / 8;
  localparam int CNT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RRESP} state_t;

  state_t                state, state_nxt;
  logic                  owner, owner_nxt;
  logic                  last, last_nxt;
  logic [CNT_BITS-1:0]   cnt, cnt_nxt;

  logic                  own_req_valid;
  logic [ADDR_BITS-1:0]  own_req_addr;
  logic                  own_req_rw;
  logic                  own_data_valid;
  logic [DATA_BITS-1:0]  own_data_bits;
  logic [MASK_BITS-1:0]  own_data_mask;

  logic                  grant_req_ready;
  logic                  grant_data_ready;
  logic                  grant_resp_valid;

  assign own_req_valid  = owner ? c1_req_valid      : c0_req_valid;
  assign own_req_addr   = owner ? c1_req_addr       : c0_req_addr;
  assign own_req_rw     = owner ? c1_req_rw         : c0_req_rw;
  assign own_data_valid = owner ? c1_req_data_valid : c0_req_data_valid;
  assign own_data_bits  = owner ? c1_req_data_bits  : c0_req_data_bits;
  assign own_data_mask  = owner ? c1_req_data_mask  : c0_req_data_mask;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt          = state;
    owner_nxt          = owner;
    last_nxt           = last;
    cnt_nxt            = cnt;
    mem_req_valid      = 1'b0;
    mem_req_addr       = '0;
    mem_req_rw         = 1'b0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;
    grant_req_ready    = 1'b0;
    grant_data_ready   = 1'b0;
    grant_resp_valid   = 1'b0;

    case (state)
      IDLE: begin
        if (c0_req_valid && c1_req_valid) begin
          owner_nxt = ~last;
          state_nxt = ADDR;
        end else if (c0_req_valid) begin
          owner_nxt = 1'b0;
          state_nxt = ADDR;
        end else if (c1_req_valid) begin
          owner_nxt = 1'b1;
          state_nxt = ADDR;
        end
      end

      ADDR: begin
        // A client that drops valid here keeps the grant; memory just sees valid fall.
        mem_req_valid   = own_req_valid;
        mem_req_addr    = own_req_addr;
        mem_req_rw      = own_req_rw;
        grant_req_ready = mem_req_ready;
        if (own_req_valid && mem_req_ready) begin
          if (own_req_rw) begin
            state_nxt = WDATA;
          end else begin
            state_nxt = RRESP;
            cnt_nxt   = '0;
          end
        end
      end

      WDATA: begin
        mem_req_data_valid = own_data_valid;
        mem_req_data_bits  = own_data_bits;
        mem_req_data_mask  = own_data_mask;
        grant_data_ready   = mem_req_data_ready;
        if (own_data_valid && mem_req_data_ready) begin
          last_nxt  = owner;
          state_nxt = IDLE;
        end
      end

      RRESP: begin
        grant_resp_valid = mem_resp_valid;
        if (mem_resp_valid) begin
          if (cnt == LAST_BEAT) begin
            last_nxt  = owner;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_BITS'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Only the handshake strobes are routed; response data is broadcast to both clients.
  assign c0_req_ready      = grant_req_ready  & ~owner;
  assign c1_req_ready      = grant_req_ready  &  owner;
  assign c0_req_data_ready = grant_data_ready & ~owner;
  assign c1_req_data_ready = grant_data_ready &  owner;
  assign c0_resp_valid     = grant_resp_valid & ~owner;
  assign c1_resp_valid     = grant_resp_valid &  owner;
  assign c0_resp_data      = mem_resp_data;
  assign c1_resp_data      = mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table plus hand-written
// sequences for stalls, tie alternation and reset in the middle of a read.
module tb_mem_arbiter;

  localparam int AB = 28;
  localparam int DB = 128;
  localparam int MB = DB / 8;

  localparam logic [AB-1:0] C0_ADDR = 28'h0000123;
  localparam logic [AB-1:0] C1_ADDR = 28'h00000FF;
  localparam logic [DB-1:0] C0_BITS = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [DB-1:0] C1_BITS = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
  localparam logic [MB-1:0] C0_MASK = 16'h00FF;
  localparam logic [MB-1:0] C1_MASK = 16'hFFFF;

  logic          clk, reset;
  logic          c0_req_valid, c0_req_ready, c0_req_rw, c0_req_data_valid, c0_req_data_ready;
  logic [AB-1:0] c0_req_addr;
  logic [DB-1:0] c0_req_data_bits, c0_resp_data;
  logic [MB-1:0] c0_req_data_mask;
  logic          c0_resp_valid;
  logic          c1_req_valid, c1_req_ready, c1_req_rw, c1_req_data_valid, c1_req_data_ready;
  logic [AB-1:0] c1_req_addr;
  logic [DB-1:0] c1_req_data_bits, c1_resp_data;
  logic [MB-1:0] c1_req_data_mask;
  logic          c1_resp_valid;
  logic          mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
  logic [AB-1:0] mem_req_addr;
  logic [DB-1:0] mem_req_data_bits, mem_resp_data;
  logic [MB-1:0] mem_req_data_mask;
  logic          mem_resp_valid;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_addr(c0_req_addr),
    .c0_req_rw(c0_req_rw), .c0_req_data_valid(c0_req_data_valid),
    .c0_req_data_ready(c0_req_data_ready), .c0_req_data_bits(c0_req_data_bits),
    .c0_req_data_mask(c0_req_data_mask), .c0_resp_valid(c0_resp_valid),
    .c0_resp_data(c0_resp_data),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_addr(c1_req_addr),
    .c1_req_rw(c1_req_rw), .c1_req_data_valid(c1_req_data_valid),
    .c1_req_data_ready(c1_req_data_ready), .c1_req_data_bits(c1_req_data_bits),
    .c1_req_data_mask(c1_req_data_mask), .c1_resp_valid(c1_resp_valid),
    .c1_resp_data(c1_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mv, mrw, mdv, c0r, c1r, c0dr, c1dr, c0rv, c1rv}
  logic [8:0] outs;
  assign outs = {mem_req_valid, mem_req_rw, mem_req_data_valid, c0_req_ready, c1_req_ready,
                 c0_req_data_ready, c1_req_data_ready, c0_resp_valid, c1_resp_valid};

  // in = {c0v, c0rw, c0dv, c1v, c1rw, c1dv, mrdy, mdrdy, mrv}
  typedef struct {
    logic [8:0]    in;
    logic [7:0]    rdat;
    logic [8:0]    exp;
    logic [AB-1:0] addr;
    logic          chk_addr;
  } vec_t;

  vec_t vecs[21];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    c0_req_valid = 0; c0_req_rw = 0; c0_req_data_valid = 0;
    c1_req_valid = 0; c1_req_rw = 0; c1_req_data_valid = 0;
    mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0;
    mem_resp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic apply(input logic [8:0] in, input logic [7:0] rdat);
    {c0_req_valid, c0_req_rw, c0_req_data_valid,
     c1_req_valid, c1_req_rw, c1_req_data_valid,
     mem_req_ready, mem_req_data_ready, mem_resp_valid} = in;
    mem_resp_data = {120'b0, rdat};
  endtask

  initial begin
    c0_req_addr = C0_ADDR; c0_req_data_bits = C0_BITS; c0_req_data_mask = C0_MASK;
    c1_req_addr = C1_ADDR; c1_req_data_bits = C1_BITS; c1_req_data_mask = C1_MASK;

    // Table: c0 tie-win read, c1 write (alternation), c0 read, c1 read grant.
    vecs[0]  = '{9'b000_000_001, 8'h00, 9'b000_000_000, '0,      1'b1}; // stray resp in IDLE
    vecs[1]  = '{9'b100_100_000, 8'h00, 9'b000_000_000, '0,      1'b1}; // tie: c0 wins
    vecs[2]  = '{9'b100_100_000, 8'h00, 9'b100_000_000, C0_ADDR, 1'b1};
    vecs[3]  = '{9'b100_100_100, 8'h00, 9'b100_100_000, C0_ADDR, 1'b1};
    vecs[4]  = '{9'b000_100_001, 8'hA0, 9'b000_000_010, '0,      1'b0};
    vecs[5]  = '{9'b000_100_000, 8'h55, 9'b000_000_000, '0,      1'b0};
    vecs[6]  = '{9'b000_100_001, 8'hA1, 9'b000_000_010, '0,      1'b0};
    vecs[7]  = '{9'b000_100_001, 8'hA2, 9'b000_000_010, '0,      1'b0};
    vecs[8]  = '{9'b000_100_001, 8'hA3, 9'b000_000_010, '0,      1'b0};
    vecs[9]  = '{9'b100_110_000, 8'h00, 9'b000_000_000, '0,      1'b1}; // c1 after c0
    vecs[10] = '{9'b100_111_110, 8'h00, 9'b110_010_000, C1_ADDR, 1'b1};
    vecs[11] = '{9'b100_111_001, 8'h77, 9'b001_000_000, '0,      1'b0}; // stray in WDATA
    vecs[12] = '{9'b100_111_010, 8'h00, 9'b001_000_100, '0,      1'b0};
    vecs[13] = '{9'b100_100_001, 8'h00, 9'b000_000_000, '0,      1'b1}; // c0 after c1
    vecs[14] = '{9'b100_100_100, 8'h00, 9'b100_100_000, C0_ADDR, 1'b1};
    vecs[15] = '{9'b000_100_001, 8'hB0, 9'b000_000_010, '0,      1'b0};
    vecs[16] = '{9'b000_100_001, 8'hB1, 9'b000_000_010, '0,      1'b0};
    vecs[17] = '{9'b000_100_001, 8'hB2, 9'b000_000_010, '0,      1'b0};
    vecs[18] = '{9'b000_100_001, 8'hB3, 9'b000_000_010, '0,      1'b0};
    vecs[19] = '{9'b000_100_001, 8'h00, 9'b000_000_000, '0,      1'b1};
    vecs[20] = '{9'b000_100_100, 8'h00, 9'b100_010_000, C1_ADDR, 1'b1};

    reset = 1;
    idle_inputs();
    step();
    #1;
    check("in_reset_outs", outs, 9'b0);
    step();
    reset = 0;
    #1;
    check("reset_outs", outs, 9'b0);
    check("reset_addr", mem_req_addr, '0);
    check("reset_bits", mem_req_data_bits, '0);
    check("reset_mask", mem_req_data_mask, '0);

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i].in, vecs[i].rdat);
      #1;
      check($sformatf("vec%0d_outs", i), outs, vecs[i].exp);
      check($sformatf("vec%0d_c0_data", i), c0_resp_data, {120'b0, vecs[i].rdat});
      check($sformatf("vec%0d_c1_data", i), c1_resp_data, {120'b0, vecs[i].rdat});
      if (vecs[i].chk_addr)
        check($sformatf("vec%0d_addr", i), mem_req_addr, vecs[i].addr);
      step();
    end

    // Stalls plus strict alternation with both clients writing and held.
    do_reset();
    c0_req_valid = 1; c0_req_rw = 1; c0_req_data_valid = 1;
    c1_req_valid = 1; c1_req_rw = 1; c1_req_data_valid = 1;
    mem_req_data_ready = 1;
    #1;
    check("stall_idle_valid", mem_req_valid, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall_a%0d_valid", i), mem_req_valid, 1'b1);
      check($sformatf("stall_a%0d_addr", i), mem_req_addr, C0_ADDR);
      check($sformatf("stall_a%0d_rdy", i), {c0_req_ready, c1_req_ready, c0_req_data_ready,
                                              mem_req_data_valid}, 4'b0);
      step();
    end
    mem_req_ready = 1;
    #1;
    check("stall_afire_rdy", {c0_req_ready, c1_req_ready}, 2'b10);
    step();
    mem_req_data_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_w%0d_dv", i), {mem_req_valid, mem_req_data_valid}, 2'b01);
      check($sformatf("stall_w%0d_bits", i), mem_req_data_bits, C0_BITS);
      check($sformatf("stall_w%0d_mask", i), mem_req_data_mask, C0_MASK);
      check($sformatf("stall_w%0d_drdy", i), {c0_req_data_ready, c1_req_data_ready}, 2'b00);
      step();
    end
    mem_req_data_ready = 1;
    #1;
    check("stall_wfire_drdy", {c0_req_data_ready, c1_req_data_ready}, 2'b10);
    step();
    #1;
    check("alt_idle1_valid", mem_req_valid, 1'b0);
    step();
    #1;
    check("alt_c1_addr", mem_req_addr, C1_ADDR);
    check("alt_c1_rdy", {c0_req_ready, c1_req_ready}, 2'b01);
    step();
    #1;
    check("alt_c1_bits", mem_req_data_bits, C1_BITS);
    check("alt_c1_mask", mem_req_data_mask, C1_MASK);
    check("alt_c1_drdy", {c0_req_data_ready, c1_req_data_ready}, 2'b01);
    step();
    #1;
    check("alt_idle2_valid", mem_req_valid, 1'b0);
    step();
    #1;
    check("alt_c0_again_addr", mem_req_addr, C0_ADDR);
    check("alt_c0_again_rdy", {c0_req_ready, c1_req_ready}, 2'b10);

    // Reset after 2 of 4 beats, then a fresh read must see 4 full beats.
    do_reset();
    c0_req_valid = 1; mem_req_ready = 1;
    step();
    step();
    c0_req_valid = 0; mem_resp_valid = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("rst_pre_beat%0d", i), c0_resp_valid, 1'b1);
      step();
    end
    reset = 1;
    step();
    reset = 0;
    #1;
    check("rst_idle_resp", {c0_resp_valid, c1_resp_valid, mem_req_valid}, 3'b0);
    mem_resp_valid = 0; c0_req_valid = 1;
    step();
    #1;
    check("rst_new_addr", {mem_req_valid, c0_req_ready}, 2'b11);
    step();
    c0_req_valid = 0; mem_resp_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rst_new_beat%0d", i), c0_resp_valid, 1'b1);
      step();
    end
    #1;
    check("rst_after_beats", {c0_resp_valid, c1_resp_valid}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
